// File: rtl/traffic_pkg.sv
// traffic_pkg: state codes, light codes and period constants shared by the sequencer and its counter.
package traffic_pkg;
    typedef logic [2:0] state_t;
    typedef logic [2:0] light_t;
    localparam logic [2:0] NS_GREEN    = 3'd0;
    localparam logic [2:0] NS_YELLOW   = 3'd1;
    localparam logic [2:0] EW_GREEN    = 3'd2;
    localparam logic [2:0] EW_YELLOW   = 3'd3;
    localparam logic [2:0] NIGHT_FLASH = 3'd4;
    localparam logic [2:0] FAULT       = 3'd5;
    localparam light_t RED    = 3'b100;
    localparam light_t YELLOW = 3'b010;
    localparam light_t GREEN  = 3'b001;
    localparam light_t DARK   = 3'b000;
    localparam int GREEN_COUNT  = 25;
    localparam int PERIOD_COUNT = 30;
endpackage

// File: rtl/traffic_light_fsm_if.sv
// traffic_light_fsm_if: timeout/request inputs and light outputs; ped signals exist only with PED_WALK_EN.
interface traffic_light_fsm_if;
    import traffic_pkg::*;
    logic   timeout25;
    logic   timeout30;
    logic   night_mode;
    light_t ns_light;
    light_t ew_light;
    state_t phase;
    logic   fault;
`ifdef PED_WALK_EN
    logic   ped_req;
    logic   ped_walk;
    modport master (output timeout25, timeout30, night_mode, ped_req,
                    input ns_light, ew_light, phase, fault, ped_walk);
    modport slave (input timeout25, timeout30, night_mode, ped_req,
                   output ns_light, ew_light, phase, fault, ped_walk);
`else
    modport master (output timeout25, timeout30, night_mode,
                    input ns_light, ew_light, phase, fault);
    modport slave (input timeout25, timeout30, night_mode,
                   output ns_light, ew_light, phase, fault);
`endif
endinterface

// File: rtl/traffic_light_fsm_light_decoder.sv
// light_decoder: Moore decode of sequencer state and flash level into per-road one-hot lights.
module light_decoder
    import traffic_pkg::*;
(
    input  state_t state,
    input  logic   blink,
    output light_t ns_light,
    output light_t ew_light
);
    light_t flash;
    always_comb begin
        flash    = blink ? YELLOW : DARK;
        ns_light = state == NS_GREEN    ? GREEN  :
                   state == NS_YELLOW   ? YELLOW :
                   state == NIGHT_FLASH ? flash  : RED;
        ew_light = state == EW_GREEN    ? GREEN  :
                   state == EW_YELLOW   ? YELLOW :
                   state == NIGHT_FLASH ? flash  : RED;
    end
endmodule

// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm: NS/EW phase sequencer driven by counter timeouts, with night flash and sticky fault.
// Optional pedestrian walk phase across EW is enabled by defining PED_WALK_EN.
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter logic START_EW       = 1'b0,
    parameter logic NIGHT_BLINK_ON = 1'b1
)(
    input logic clk1,
    input logic rst,
    traffic_light_fsm_if.slave bus
);
    state_t state, state_next;
    logic   blink, fault_q, t25, t30, night;
    always_comb begin
        t25   = bus.timeout25;
        t30   = bus.timeout30;
        night = bus.night_mode;
        state_next = (t25 && t30)            ? FAULT :
                     state == NS_GREEN       ? (t30 ? FAULT : t25 ? NS_YELLOW : NS_GREEN) :
                     state == NS_YELLOW      ? (t25 ? FAULT : t30 ? (night ? NIGHT_FLASH : EW_GREEN) : NS_YELLOW) :
                     state == EW_GREEN       ? (t30 ? FAULT : t25 ? EW_YELLOW : EW_GREEN) :
                     state == EW_YELLOW      ? (t25 ? FAULT : t30 ? (night ? NIGHT_FLASH : NS_GREEN) : EW_YELLOW) :
                     state == NIGHT_FLASH    ? ((t30 && !night) ? NS_GREEN : NIGHT_FLASH) : FAULT;
    end
    always_ff @(posedge clk1) begin
        if (rst) begin
            state   <= START_EW ? EW_GREEN : NS_GREEN;
            blink   <= NIGHT_BLINK_ON;
            fault_q <= 1'b0;
        end else begin
            state   <= state_next;
            fault_q <= fault_q | (state_next == FAULT);
            // entry always restarts the flash at its configured level
            if (state_next == NIGHT_FLASH)
                blink <= (state != NIGHT_FLASH) ? NIGHT_BLINK_ON : (t30 ? ~blink : blink);
        end
    end
    light_decoder u_dec (
        .state    (state),
        .blink    (blink),
        .ns_light (bus.ns_light),
        .ew_light (bus.ew_light)
    );
    assign bus.phase = state;
    assign bus.fault = fault_q;
`ifdef PED_WALK_EN
    logic ped_pending, walk, entering;
    assign entering = (state_next == NS_GREEN) && (state != NS_GREEN);
    always_ff @(posedge clk1) begin
        if (rst) begin
            ped_pending <= 1'b0;
            walk        <= 1'b0;
        end else begin
            ped_pending <= (state_next == FAULT || entering) ? 1'b0 : (ped_pending | bus.ped_req);
            walk        <= entering ? (ped_pending | bus.ped_req) : (walk && state_next == NS_GREEN);
        end
    end
    assign bus.ped_walk = walk;
`endif
endmodule
